sia_dispatch: RTL and testbench

Single-job work dispatcher and result collector for one `siacore` instance. It accepts a 640-bit block header and a 64-bit target from the host over a ready/valid channel and issues them to the core with a one-cycle `valid` pulse. It then watches `found`/`nonce`/`busy` and returns one tagged result per job (found nonce, range exhausted, or timeout) on a second ready/valid channel. It is the driving end of the core's work/found interface and sits between the host register block and `siacore`.

---
 rtl/sia_pkg.sv | 18 +
 rtl/sia_job_timer.sv | 23 ++
 rtl/sia_dispatch.sv | 102 ++++++++++
 tb/tb_sia_dispatch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sia_pkg.sv
// Shared widths, result status codes, FSM state and result record for the siacore dispatcher.
package sia_pkg;
  localparam int WORK_W   = 640;
  localparam int TARGET_W = 64;
  localparam int NONCE_W  = 32;
  localparam int TAG_W    = 8;

  localparam logic [1:0] ST_FOUND     = 2'b00;
  localparam logic [1:0] ST_EXHAUSTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_e;

  typedef struct packed {
    logic [1:0]         status;
    logic [NONCE_W-1:0] nonce;
  } res_t;
endpackage

// File: rtl/sia_job_timer.sv
// Per-job cycle counter; o_tc flags the last WAIT cycle before a timeout is declared.
module sia_job_timer #(
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [TIMEOUT_W-1:0] TC = TIMEOUT - 1'b1;

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == TC);
endmodule

// File: rtl/sia_dispatch.sv
// Single-job dispatcher: accepts one job, pulses it into siacore, returns one tagged result.
module sia_dispatch
  import sia_pkg::*;
#(
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                work_valid,
  output logic                work_ready,
  input  logic [WORK_W-1:0]   work_data,
  input  logic [TARGET_W-1:0] work_target,
  output logic [WORK_W-1:0]   core_work,
  output logic [TARGET_W-1:0] core_target,
  output logic                core_valid,
  input  logic                core_found,
  input  logic [NONCE_W-1:0]  core_nonce,
  input  logic                core_busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [1:0]          res_status,
  output logic [TAG_W-1:0]    res_tag,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic                idle
);
  state_e              r_state, w_next;
  logic                r_rst_done;
  logic                r_busy_seen;
  logic [WORK_W-1:0]   r_work;
  logic [TARGET_W-1:0] r_target;
  logic [TAG_W-1:0]    r_tag;
  res_t                r_res;
  logic                w_tc, w_accept, w_exhausted, w_done;

  sia_job_timer #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == S_ISSUE),
    .i_en  (r_state == S_WAIT),
    .o_tc  (w_tc)
  );

  // r_busy_seen only reflects earlier WAIT cycles, so a job never exhausts before the core starts.
  assign w_accept    = work_valid && work_ready;
  assign w_exhausted = r_busy_seen && !core_busy;
  assign w_done      = core_found || w_exhausted || w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (w_done) w_next = S_REPORT;
      S_REPORT: if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    idle       = (r_state == S_IDLE);
    work_ready = idle && r_rst_done;
    core_valid = (r_state == S_ISSUE);
    res_valid  = (r_state == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done  <= 1'b0;
      r_busy_seen <= 1'b0;
      r_work      <= '0;
      r_target    <= '0;
      r_tag       <= '0;
      r_res       <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_accept) begin
        r_work   <= work_data;
        r_target <= work_target;
      end
      if (r_state == S_ISSUE)                  r_busy_seen <= 1'b0;
      else if (r_state == S_WAIT && core_busy) r_busy_seen <= 1'b1;
      if (r_state == S_WAIT && w_done) begin
        if (core_found)       r_res <= '{status: ST_FOUND, nonce: core_nonce};
        else if (w_exhausted) r_res <= '{status: ST_EXHAUSTED, nonce: '0};
        else                  r_res <= '{status: ST_TIMEOUT, nonce: '0};
      end
      if (res_valid && res_ready) r_tag <= r_tag + 1'b1;
    end
  end

  assign core_work   = r_work;
  assign core_target = r_target;
  assign res_status  = r_res.status;
  assign res_nonce   = r_res.nonce;
  assign res_tag     = r_tag;
endmodule

// File: tb/tb_sia_dispatch.sv
// Randomized bench for sia_dispatch with a per-job event-script reference model.
module tb_sia_dispatch;
  localparam int TMO = 8;
  localparam logic [1:0] FOUND = 2'd0, EXH = 2'd1, TOUT = 2'd2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic work_valid = 1'b0, work_ready;
  logic [639:0] work_data = '0, core_work;
  logic [63:0]  work_target = '0, core_target;
  logic core_valid, core_found = 1'b0, core_busy = 1'b0;
  logic [31:0] core_nonce = '0, res_nonce;
  logic res_valid, res_ready = 1'b0, idle;
  logic [1:0] res_status;
  logic [7:0] res_tag;

  sia_dispatch #(.TIMEOUT_W(16), .TIMEOUT(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(work_ready),
    .work_data(work_data), .work_target(work_target), .core_work(core_work),
    .core_target(core_target), .core_valid(core_valid), .core_found(core_found),
    .core_nonce(core_nonce), .core_busy(core_busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_status(res_status), .res_tag(res_tag),
    .res_nonce(res_nonce), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [7:0]   exp_tag = '0;
  logic         busy_s [0:15];
  logic         found_s[0:15];
  logic [31:0]  job_nonce;
  logic [639:0] exp_work;
  logic [63:0]  exp_target;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_script();
    for (int j = 0; j < 16; j++) begin busy_s[j] = 1'b0; found_s[j] = 1'b0; end
    job_nonce = $urandom;
  endtask

  // First event wins: found, then busy-dropped-after-being-seen, then the timeout cycle.
  function automatic void model(output int kend, output logic [1:0] st, output logic [31:0] nn);
    bit seen = 0;
    kend = TMO - 1; st = TOUT; nn = '0;
    for (int j = 0; j < TMO; j++) begin
      if (found_s[j])            begin kend = j; st = FOUND; nn = job_nonce; return; end
      if (seen && !busy_s[j])    begin kend = j; st = EXH; return; end
      seen = seen | busy_s[j];
    end
  endfunction

  // Leaves the caller at the negedge of the first WAIT cycle.
  task automatic start_job(input logic [31:0] nonce_field);
    int w = 0;
    while (!work_ready && w < 8) begin @(negedge clk); w++; end
    check("work_ready_before_accept", work_ready, 1'b1);
    for (int i = 0; i < 20; i++) exp_work[i*32 +: 32] = $urandom;
    exp_work[287:256] = nonce_field;
    exp_target = {$urandom, $urandom};
    work_data = exp_work; work_target = exp_target; work_valid = 1'b1;
    @(negedge clk);
    check("core_valid_pulse", core_valid, 1'b1);
    check("core_work", core_work, exp_work);
    check("core_target", core_target, exp_target);
    work_valid = 1'b0; work_data = '0;
    @(negedge clk);
    check("core_valid_single", core_valid, 1'b0);
  endtask

  task automatic run_job(input logic [31:0] nonce_field, input int hold);
    int kend; logic [1:0] st; logic [31:0] nn;
    model(kend, st, nn);
    start_job(nonce_field);
    for (int j = 0; j <= kend + 1; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("res_valid_at_wait%0d", j), res_valid, j == kend + 1);
      if (j == kend + 1) break;
      core_busy  = busy_s[j];
      core_found = found_s[j];
      core_nonce = found_s[j] ? job_nonce : $urandom;
    end
    core_busy = 1'b0; core_found = 1'b0;
    check("res_status", res_status, st);
    check("res_tag", res_tag, exp_tag);
    check("res_nonce", res_nonce, nn);
    check("core_work_held", core_work, exp_work);
    for (int h = 0; h < hold; h++) begin
      core_found = 1'b1;
      @(negedge clk);
      core_found = 1'b0;
      check("hold_res_valid", res_valid, 1'b1);
      check("hold_work_ready", work_ready, 1'b0);
      check("hold_result", {res_status, res_tag, res_nonce}, {st, exp_tag, nn});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_tag = exp_tag + 8'd1;
    check("res_valid_after_ack", res_valid, 1'b0);
    check("idle_after_ack", idle, 1'b1);
    check("tag_after_ack", res_tag, exp_tag);
  endtask

  initial begin
    #2;
    check("rst_work_ready", work_ready, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_core_valid", core_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_outputs", {core_work, core_target, res_status, res_tag, res_nonce}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    check("post_rst_work_ready", work_ready, 1'b1);
    check("post_rst_idle", idle, 1'b1);
    for (int i = 0; i < 3; i++) begin
      core_found = 1'b1; core_nonce = $urandom;
      @(negedge clk);
      check("idle_found_ignored", res_valid, 1'b0);
    end
    core_found = 1'b0;

    // Found six cycles after busy rises
    clear_script(); job_nonce = 32'h0000000F;
    for (int j = 0; j <= 6; j++) busy_s[j] = 1'b1;
    found_s[6] = 1'b1;
    run_job(32'h0A000000, 0);

    // Exhausted: busy 5 cycles then low
    clear_script();
    for (int j = 0; j < 5; j++) busy_s[j] = 1'b1;
    run_job($urandom, 0);

    // Timeout, result held for 10 cycles with stray found pulses
    clear_script();
    run_job($urandom, 10);

    // Found on the same edge busy falls
    clear_script();
    for (int j = 0; j < 3; j++) busy_s[j] = 1'b1;
    found_s[3] = 1'b1;
    run_job($urandom, 0);

    // Found on the timeout cycle
    clear_script();
    found_s[TMO-1] = 1'b1;
    run_job($urandom, 0);

    // Random jobs, enough to wrap the tag
    for (int n = 0; n < 260; n++) begin
      int bs, bl;
      clear_script();
      bs = $urandom_range(0, 3); bl = $urandom_range(0, 6);
      for (int j = bs; j < bs + bl; j++) busy_s[j] = 1'b1;
      if ($urandom_range(0, 1) == 1) found_s[$urandom_range(0, 9)] = 1'b1;
      run_job($urandom, $urandom_range(0, 2));
    end

    // Reset in the middle of WAIT
    clear_script();
    start_job($urandom);
    core_busy = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_tag", res_tag, 8'd0);
    check("midrst_idle", idle, 1'b1);
    check("midrst_core_valid", core_valid, 1'b0);
    check("midrst_core_target", core_target, 64'd0);
    core_busy = 1'b0;
    exp_tag = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_core_valid", core_valid, 1'b0);
    end
    clear_script();
    busy_s[0] = 1'b1; busy_s[1] = 1'b1;
    run_job($urandom, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
